// File: rtl/airlock_pkg.sv
// ============================================================================
// Module   : airlock_pkg
// Purpose  : Shared types, default constants and output decode for the
//            airlock chamber sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package airlock_pkg;

  // Sequencer states. INIT is only ever occupied straight out of reset.
  typedef enum logic [2:0] {
    ST_INIT          = 3'd0,
    ST_PRESSURIZED   = 3'd1,
    ST_DEPRESSURIZED = 3'd2,
    ST_PRESS         = 3'd3,
    ST_DEPRESS       = 3'd4,
    ST_INNER_OPEN    = 3'd5,
    ST_OUTER_OPEN    = 3'd6,
    ST_FAULT         = 3'd7
  } airlock_state_t;

  // Default configuration of a flight unit.
  localparam logic [7:0] c_DEF_P_HIGH         = 8'd100;
  localparam logic [7:0] c_DEF_P_LOW          = 8'd0;
  localparam int         c_DEF_DOOR_CYCLES    = 8;
  localparam int         c_DEF_TIMEOUT_CYCLES = 1000;
  localparam int         c_DEF_TW             = 16;

  // Complete set of registered controller outputs.
  typedef struct packed {
    logic start_press;
    logic start_depress;
    logic inner_open;
    logic outer_open;
    logic busy;
    logic fault;
  } airlock_out_t;

  // Moore decode: outputs depend only on the state being entered and on
  // whether any crew request is still waiting to be served.
  function automatic airlock_out_t decode_outputs(input airlock_state_t st,
                                                  input logic pend_any);
    airlock_out_t o;
    o = '0;
    case (st)
      ST_PRESS: begin
        o.start_press = 1'b1;
        o.busy        = 1'b1;
      end
      ST_DEPRESS: begin
        o.start_depress = 1'b1;
        o.busy          = 1'b1;
      end
      ST_INNER_OPEN: begin
        o.inner_open = 1'b1;
        o.busy       = 1'b1;
      end
      ST_OUTER_OPEN: begin
        o.outer_open = 1'b1;
        o.busy       = 1'b1;
      end
      ST_PRESSURIZED,
      ST_DEPRESSURIZED: begin
        o.busy = pend_any;
      end
      ST_FAULT: begin
        o.fault = 1'b1;
        o.busy  = 1'b1;
      end
      default: begin
        o.busy = 1'b1;
      end
    endcase
    return o;
  endfunction

endpackage

`default_nettype wire

// File: rtl/airlock_timer.sv
// ============================================================================
// Module   : airlock_timer
// Purpose  : Shared up-counter for door hold time and pump timeout. Clears
//            synchronously on request and flags when the selected last
//            cycle has been reached.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module airlock_timer #(
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_sel_door,
  input  logic [TW-1:0] i_door_last,
  input  logic [TW-1:0] i_timeout_last,
  output logic          o_done
);

  logic [TW-1:0] r_count;
  logic [TW-1:0] w_limit;

  // Count cycles spent in the current state; saturate so an idle state can
  // sit indefinitely without the count wrapping back through a limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (r_count != {TW{1'b1}}) begin
      r_count <= r_count + TW'(1);
    end
  end

  // Pick the limit matching the activity being timed.
  assign w_limit = i_sel_door ? i_door_last : i_timeout_last;
  assign o_done  = (r_count == w_limit);

endmodule

`default_nettype wire

// File: rtl/airlock_controller.sv
// ============================================================================
// Module   : airlock_controller
// Purpose  : Airlock chamber sequencer. Arbitrates cabin-side and vacuum-side
//            crew requests, drives the pressure pump and opens one door only
//            when the chamber pressure matches that side. A pump that fails
//            to reach its target in time latches a sticky fault.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module airlock_controller
  import airlock_pkg::*;
#(
  parameter logic [7:0] P_HIGH         = c_DEF_P_HIGH,
  parameter logic [7:0] P_LOW          = c_DEF_P_LOW,
  parameter int         DOOR_CYCLES    = c_DEF_DOOR_CYCLES,
  parameter int         TIMEOUT_CYCLES = c_DEF_TIMEOUT_CYCLES,
  parameter int         TW             = c_DEF_TW
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       innerRequest,
  input  logic       outerRequest,
  input  logic [7:0] pressure,
  output logic       startPressurization,
  output logic       startDepressurization,
  output logic       innerDoorOpen,
  output logic       outerDoorOpen,
  output logic       busy,
  output logic       fault
);

  // Timer values for the final cycle of a door hold and of a pump run.
  localparam logic [TW-1:0] c_DOOR_LAST    = TW'(DOOR_CYCLES - 1);
  localparam logic [TW-1:0] c_TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  airlock_state_t r_state;
  airlock_state_t w_next_state;

  logic r_inner_pend;
  logic r_outer_pend;
  logic w_inner_pend_next;
  logic w_outer_pend_next;

  logic w_at_high;
  logic w_at_low;
  logic w_timer_clear;
  logic w_timer_sel_door;
  logic w_timer_done;

  airlock_out_t r_out;
  airlock_out_t w_out_next;

  // Pressure thresholds; the low side is written as "not above" so that a
  // zero P_LOW does not turn into a constant comparison.
  assign w_at_high = (pressure >= P_HIGH);
  assign w_at_low  = !(pressure > P_LOW);

  // Door states use the hold limit; everything else uses the pump timeout.
  assign w_timer_sel_door = (r_state == ST_INNER_OPEN) ||
                            (r_state == ST_OUTER_OPEN);

  // Every state change restarts the timer from zero.
  assign w_timer_clear = (w_next_state != r_state);

  airlock_timer #(
    .TW (TW)
  ) u_timer (
    .clk            (clock),
    .rst            (reset),
    .i_clear        (w_timer_clear),
    .i_sel_door     (w_timer_sel_door),
    .i_door_last    (c_DOOR_LAST),
    .i_timeout_last (c_TIMEOUT_LAST),
    .o_done         (w_timer_done)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state selection. At rest, the door matching the current pressure
  // wins; the opposite request waits and is reached through a pump state.
  // In pump states reaching the threshold beats the timeout.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_INIT: begin
        w_next_state = w_at_high ? ST_PRESSURIZED : ST_PRESS;
      end
      ST_PRESSURIZED: begin
        if (r_inner_pend) begin
          w_next_state = ST_INNER_OPEN;
        end else if (r_outer_pend) begin
          w_next_state = ST_DEPRESS;
        end
      end
      ST_DEPRESSURIZED: begin
        if (r_outer_pend) begin
          w_next_state = ST_OUTER_OPEN;
        end else if (r_inner_pend) begin
          w_next_state = ST_PRESS;
        end
      end
      ST_PRESS: begin
        if (w_at_high) begin
          w_next_state = ST_PRESSURIZED;
        end else if (w_timer_done) begin
          w_next_state = ST_FAULT;
        end
      end
      ST_DEPRESS: begin
        if (w_at_low) begin
          w_next_state = ST_DEPRESSURIZED;
        end else if (w_timer_done) begin
          w_next_state = ST_FAULT;
        end
      end
      ST_INNER_OPEN: begin
        if (w_timer_done) begin
          w_next_state = ST_PRESSURIZED;
        end
      end
      ST_OUTER_OPEN: begin
        if (w_timer_done) begin
          w_next_state = ST_DEPRESSURIZED;
        end
      end
      ST_FAULT: begin
        w_next_state = ST_FAULT;
      end
      default: begin
        w_next_state = ST_INIT;
      end
    endcase
  end

  // Request capture: a request is remembered until its door grant starts.
  // Requests for a door that is already open, and any request while
  // faulted, are dropped.
  always_comb begin
    w_inner_pend_next = r_inner_pend;
    w_outer_pend_next = r_outer_pend;
    if (r_state != ST_FAULT) begin
      if (innerRequest && (r_state != ST_INNER_OPEN)) begin
        w_inner_pend_next = 1'b1;
      end
      if (outerRequest && (r_state != ST_OUTER_OPEN)) begin
        w_outer_pend_next = 1'b1;
      end
    end
    if ((w_next_state == ST_INNER_OPEN) && (r_state != ST_INNER_OPEN)) begin
      w_inner_pend_next = 1'b0;
    end
    if ((w_next_state == ST_OUTER_OPEN) && (r_state != ST_OUTER_OPEN)) begin
      w_outer_pend_next = 1'b0;
    end
  end

  // Pending request flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_inner_pend <= 1'b0;
      r_outer_pend <= 1'b0;
    end else begin
      r_inner_pend <= w_inner_pend_next;
      r_outer_pend <= w_outer_pend_next;
    end
  end

  // Decode outputs for the state being entered so they change together
  // with the state register and come straight from flops.
  assign w_out_next = decode_outputs(w_next_state,
                                     w_inner_pend_next | w_outer_pend_next);

  // Output register; reset drops every pump and door command at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out <= '0;
    end else begin
      r_out <= w_out_next;
    end
  end

  assign startPressurization   = r_out.start_press;
  assign startDepressurization = r_out.start_depress;
  assign innerDoorOpen         = r_out.inner_open;
  assign outerDoorOpen         = r_out.outer_open;
  assign busy                  = r_out.busy;
  assign fault                 = r_out.fault;

  // Safety interlocks.
  a_one_door_only : assert property (@(posedge clock) disable iff (reset)
    !(innerDoorOpen && outerDoorOpen));

  a_no_door_while_pumping : assert property (@(posedge clock) disable iff (reset)
    !((innerDoorOpen || outerDoorOpen) &&
      (startPressurization || startDepressurization)));

  a_one_pump_direction : assert property (@(posedge clock) disable iff (reset)
    !(startPressurization && startDepressurization));

endmodule

`default_nettype wire

// File: tb/tb_airlock_controller.sv
// ============================================================================
// Module   : tb_airlock_controller
// Purpose  : Self-checking bench for airlock_controller with a pressure
//            plant model and a phase-level reference model of the airlock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_airlock_controller;

  localparam logic [7:0] P_HIGH = 8'd20;
  localparam logic [7:0] P_LOW  = 8'd0;
  localparam int         DOOR   = 4;
  localparam int         TMO    = 64;

  logic       clock        = 1'b0;
  logic       reset        = 1'b1;
  logic       innerRequest = 1'b0;
  logic       outerRequest = 1'b0;
  logic [7:0] pressure     = 8'd0;
  logic [7:0] freeze_at    = 8'hFF;

  logic startP, startD, innerD, outerD, busy, fault;

  int n_vec = 0;
  int n_err = 0;
  int cnt_sp, cnt_sd, cnt_id, cnt_od;

  airlock_controller #(
    .P_HIGH         (P_HIGH),
    .P_LOW          (P_LOW),
    .DOOR_CYCLES    (DOOR),
    .TIMEOUT_CYCLES (TMO),
    .TW             (16)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .innerRequest          (innerRequest),
    .outerRequest          (outerRequest),
    .pressure              (pressure),
    .startPressurization   (startP),
    .startDepressurization (startD),
    .innerDoorOpen         (innerD),
    .outerDoorOpen         (outerD),
    .busy                  (busy),
    .fault                 (fault)
  );

  always #5 clock = ~clock;

  // Pressure plant: one unit per cycle toward the target of whichever pump
  // command is active; a stuck pump is emulated by freezing at freeze_at.
  always @(posedge clock) begin
    if (startP && (pressure < P_HIGH) && (pressure != freeze_at))
      pressure <= pressure + 8'd1;
    else if (startD && (pressure > P_LOW) && (pressure != freeze_at))
      pressure <= pressure - 8'd1;
  end

  // ---------------- reference model (phase + time-in-phase) ----------------
  localparam logic [2:0] PH_BOOT       = 3'd0;
  localparam logic [2:0] PH_FULL_IDLE  = 3'd1;
  localparam logic [2:0] PH_EMPTY_IDLE = 3'd2;
  localparam logic [2:0] PH_FILLING    = 3'd3;
  localparam logic [2:0] PH_DRAINING   = 3'd4;
  localparam logic [2:0] PH_CABIN_DOOR = 3'd5;
  localparam logic [2:0] PH_SPACE_DOOR = 3'd6;
  localparam logic [2:0] PH_DEAD       = 3'd7;

  typedef struct packed {
    logic [2:0]  phase;
    logic [15:0] age;
    logic        pin;
    logic        pout;
  } mstate_t;

  mstate_t m = '0;

  function automatic mstate_t model_step(input mstate_t s, input logic [7:0] p,
                                         input logic ir, input logic orq);
    mstate_t    n;
    logic [2:0] go;
    logic       full;
    logic       empty;
    int         age;
    full  = (p >= P_HIGH);
    empty = !(p > P_LOW);
    age   = int'(s.age);
    go    = s.phase;
    case (s.phase)
      PH_BOOT:       go = full ? PH_FULL_IDLE : PH_FILLING;
      PH_FULL_IDLE:  if (s.pin) go = PH_CABIN_DOOR; else if (s.pout) go = PH_DRAINING;
      PH_EMPTY_IDLE: if (s.pout) go = PH_SPACE_DOOR; else if (s.pin) go = PH_FILLING;
      PH_FILLING:    if (full) go = PH_FULL_IDLE; else if (age >= TMO - 1) go = PH_DEAD;
      PH_DRAINING:   if (empty) go = PH_EMPTY_IDLE; else if (age >= TMO - 1) go = PH_DEAD;
      PH_CABIN_DOOR: if (age >= DOOR - 1) go = PH_FULL_IDLE;
      PH_SPACE_DOOR: if (age >= DOOR - 1) go = PH_EMPTY_IDLE;
      default:       go = PH_DEAD;
    endcase
    n.pin  = s.pin;
    n.pout = s.pout;
    if (s.phase != PH_DEAD) begin
      if (ir && (s.phase != PH_CABIN_DOOR)) n.pin = 1'b1;
      if (orq && (s.phase != PH_SPACE_DOOR)) n.pout = 1'b1;
    end
    if ((go == PH_CABIN_DOOR) && (s.phase != PH_CABIN_DOOR)) n.pin = 1'b0;
    if ((go == PH_SPACE_DOOR) && (s.phase != PH_SPACE_DOOR)) n.pout = 1'b0;
    n.phase = go;
    n.age   = (go == s.phase) ? (s.age + 16'd1) : 16'd0;
    return n;
  endfunction

  // Expected {startP, startD, innerDoor, outerDoor, busy, fault}.
  function automatic logic [5:0] expect_of(input mstate_t s);
    logic idle;
    idle = ((s.phase == PH_FULL_IDLE) || (s.phase == PH_EMPTY_IDLE)) &&
           !s.pin && !s.pout;
    return {s.phase == PH_FILLING, s.phase == PH_DRAINING,
            s.phase == PH_CABIN_DOOR, s.phase == PH_SPACE_DOOR,
            (s.phase != PH_BOOT) && !idle, s.phase == PH_DEAD};
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) m <= '0;
    else       m <= model_step(m, pressure, innerRequest, outerRequest);
  end

  // ---------------- checking helpers ----------------
  function automatic logic [5:0] dut_outs();
    return {startP, startD, innerD, outerD, busy, fault};
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // One cycle: compare every output against the model mid-cycle and
  // accumulate how many cycles each command was high.
  task automatic step();
    logic [5:0] got;
    logic [5:0] exp;
    @(negedge clock);
    got = dut_outs();
    exp = expect_of(m);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL cycle_compare @%0t: got %b expected %b (sP sD iD oD busy fault)",
               $time, got, exp);
    end
    cnt_sp += int'(startP);
    cnt_sd += int'(startD);
    cnt_id += int'(innerD);
    cnt_od += int'(outerD);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_counts();
    cnt_sp = 0; cnt_sd = 0; cnt_id = 0; cnt_od = 0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    clear_counts();

    // Power-up at vacuum: INIT, then pump up 0..20 (21 cycles).
    run(2);
    check("reset_outputs", int'(dut_outs()), 0);
    reset = 1'b0;
    clear_counts();
    run(30);
    check("boot_press_cycles", cnt_sp, 21);
    check("boot_idle_outputs", int'(dut_outs()), 0);

    // Cabin request while pressurized: door only, no pumping.
    clear_counts();
    innerRequest = 1'b1; run(1); innerRequest = 1'b0;
    run(10);
    check("inner_door_cycles", cnt_id, DOOR);
    check("inner_no_pump", cnt_sp + cnt_sd, 0);

    // Vacuum request while pressurized: drain 20..0 then outer door.
    clear_counts();
    outerRequest = 1'b1; run(1); outerRequest = 1'b0;
    run(32);
    check("outer_drain_cycles", cnt_sd, 21);
    check("outer_door_cycles", cnt_od, DOOR);
    check("outer_inner_closed", cnt_id, 0);
    check("outer_idle_outputs", int'(dut_outs()), 0);

    // Cabin request while depressurized: fill then inner door.
    clear_counts();
    innerRequest = 1'b1; run(1); innerRequest = 1'b0;
    run(32);
    check("refill_press_cycles", cnt_sp, 21);
    check("refill_door_cycles", cnt_id, DOOR);

    // Simultaneous requests at cabin pressure: inner, drain, outer.
    clear_counts();
    innerRequest = 1'b1; outerRequest = 1'b1; run(1);
    innerRequest = 1'b0; outerRequest = 1'b0;
    run(40);
    check("both_inner_cycles", cnt_id, DOOR);
    check("both_drain_cycles", cnt_sd, 21);
    check("both_outer_cycles", cnt_od, DOOR);
    check("both_pend_cleared", int'(dut_outs()), 0);

    // Stuck pump at 10: fault after the full timeout window.
    freeze_at = 8'd10;
    clear_counts();
    innerRequest = 1'b1; run(1); innerRequest = 1'b0;
    run(80);
    check("timeout_press_cycles", cnt_sp, TMO);
    check("fault_outputs", int'(dut_outs()), 6'b000011);
    clear_counts();
    innerRequest = 1'b1; outerRequest = 1'b1; run(3);
    innerRequest = 1'b0; outerRequest = 1'b0;
    run(8);
    check("fault_ignores_requests", cnt_sp + cnt_sd + cnt_id + cnt_od, 0);
    check("fault_sticky", int'(dut_outs()), 6'b000011);
    freeze_at = 8'hFF;
    reset = 1'b1; run(2); reset = 1'b0;
    clear_counts();
    run(20);
    check("post_fault_press_cycles", cnt_sp, 11);
    check("post_fault_idle", int'(dut_outs()), 0);

    // Reset in the middle of draining at pressure 12.
    clear_counts();
    outerRequest = 1'b1; run(1); outerRequest = 1'b0;
    for (int i = 0; i < 40 && pressure != 8'd12; i++) step();
    check("reach_p12", int'(pressure), 12);
    check("draining_before_reset", int'(startD), 1);
    #2 reset = 1'b1;
    #1 check("async_reset_outputs", int'(dut_outs()), 0);
    run(2);
    reset = 1'b0;
    clear_counts();
    run(20);
    check("resume_press_cycles", cnt_sp, 9);
    check("resume_idle", int'(dut_outs()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
